sim_sram_arb: RTL and testbench

SIM_SRAM_ARB -- requirements
Module: sim_sram_arb

---
 rtl/sim_sram_arb_if.sv | 45 ++++
 rtl/sim_sram_arb.sv | 146 ++++++++++++++
 tb/tb_sim_sram_arb.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_sram_arb_if.sv
// ----------------------------------------------------------------------------
// sim_sram_arb_if
//
// Requester-side bus of the SRAM arbiter. All requester lanes are packed
// side by side; requester k owns slice k of every packed vector.
//
//   req_i    [NumReq]          access request, held until granted
//   we_i     [NumReq]          write enable per requester
//   addr_i   [NumReq*SramAw]   word address per requester
//   wdata_i  [NumReq*Width]    write data per requester
//   wmask_i  [NumReq*Width]    bit write mask per requester
//   gnt_o    [NumReq]          one-hot grant, access accepted this cycle
//   rvalid_o [NumReq]          one-hot read-data-valid
//   rdata_o  [Width]           shared read data, meaningful with rvalid_o
//
// Modports:
//   master - the requesters (drive requests, observe grants and read data)
//   slave  - the arbiter
// ----------------------------------------------------------------------------
interface sim_sram_arb_if #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned SramAw = 3,
    parameter int unsigned Width  = 32
) ();

    logic [NumReq-1:0]        req_i;
    logic [NumReq-1:0]        we_i;
    logic [NumReq*SramAw-1:0] addr_i;
    logic [NumReq*Width-1:0]  wdata_i;
    logic [NumReq*Width-1:0]  wmask_i;
    logic [NumReq-1:0]        gnt_o;
    logic [NumReq-1:0]        rvalid_o;
    logic [Width-1:0]         rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, wmask_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wmask_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/sim_sram_arb.sv
// ----------------------------------------------------------------------------
// sim_sram_arb
//
// Round-robin arbiter placing NumReq requesters onto a single SRAM port.
// The winner is the first requesting port found searching upward from a
// rotating pointer; the pointer moves past the winner only when the SRAM
// actually accepts the access. Reads return one cycle after the grant and
// are steered back to their owner. A saturating counter records how many
// cycles saw two or more simultaneous requests.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous, active-high reset
//   bus             requester bus (sim_sram_arb_if.slave)
//   sram_req_o      SRAM request (OR of all requests)
//   sram_we_o       SRAM write enable of the winner
//   sram_addr_o     SRAM word address of the winner
//   sram_wdata_o    SRAM write data of the winner
//   sram_wmask_o    SRAM bit write mask of the winner
//   sram_gnt_i      SRAM accepts the request this cycle
//   sram_rdata_i    SRAM read data, valid one cycle after an accepted read
//   conflict_cnt_o  saturating count of contention cycles
//   cnt_clr_i       synchronous clear of conflict_cnt_o
//
// Parameters: NumReq in 2..4, SramAw address width, Width a multiple of 8.
// The interface instance must carry the same parameter values.
// ----------------------------------------------------------------------------
module sim_sram_arb #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned SramAw = 3,
    parameter int unsigned Width  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sim_sram_arb_if.slave     bus,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [Width-1:0]  sram_wdata_o,
    output logic [Width-1:0]  sram_wmask_o,
    input  logic              sram_gnt_i,
    input  logic [Width-1:0]  sram_rdata_i,
    output logic [15:0]       conflict_cnt_o,
    input  logic              cnt_clr_i
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

    logic [PtrW-1:0]   ptr_q;
    logic [PtrW-1:0]   win_idx;
    logic              win_valid;
    logic              any_req;
    logic              grant;
    logic              contention;
    logic [NumReq-1:0] rvalid_q;
    logic [15:0]       cnt_q;

    // ------------------------------------------------------------------------
    // Winner search: rotate the search start to ptr_q and take the first
    // requester found, wrapping at NumReq.
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        // NOTE: every variable written here gets a default before any
        // conditional assignment, so no path leaves it holding a stale value
        // (which would infer a latch).
        cand      = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!win_valid && bus.req_i[cand[PtrW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PtrW-1:0];
            end
        end
    end

    // Reset masks the request so nothing is granted or issued while held.
    assign any_req    = !rst_i && (|bus.req_i);
    assign grant      = any_req && sram_gnt_i;
    assign contention = $countones(bus.req_i) > 1;
    assign sram_req_o = any_req;

    // ------------------------------------------------------------------------
    // Steer the winner's lane onto the SRAM port and raise its grant bit.
    // With no request everything reads as zero.
    // ------------------------------------------------------------------------
    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        bus.gnt_o    = '0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (win_valid && (win_idx == PtrW'(j))) begin
                sram_we_o    = bus.we_i[j];
                sram_addr_o  = bus.addr_i[j*SramAw +: SramAw];
                sram_wdata_o = bus.wdata_i[j*Width +: Width];
                sram_wmask_o = bus.wmask_i[j*Width +: Width];
                bus.gnt_o[j] = grant;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State: rotating pointer, pending read owner (kept one-hot so rvalid_o
    // comes straight from a flop), and the contention counter.
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement
    // order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (grant) begin
                ptr_q <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            end

            // Only an accepted read creates a return; writes and idle
            // cycles clear any previous one, giving a fixed 1-cycle latency.
            for (int unsigned j = 0; j < NumReq; j++) begin
                rvalid_q[j] <= grant && !sram_we_o && (win_idx == PtrW'(j));
            end

            // Clear wins over a same-cycle increment.
            if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if (contention && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.rvalid_o   = rvalid_q;
    assign bus.rdata_o    = (|rvalid_q) ? sram_rdata_i : '0;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sim_sram_arb.sv
// ----------------------------------------------------------------------------
// tb_sim_sram_arb
//
// Bench for sim_sram_arb with NumReq=2, SramAw=3, Width=32. A small SRAM
// model answers the arbiter's SRAM port. A transaction-level reference
// (rotating priority, word memory, pending read, contention count) predicts
// every DUT output each cycle. Inputs change on the falling edge; outputs
// are sampled 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_sim_sram_arb;

    localparam int NR    = 2;
    localparam int AW    = 3;
    localparam int W     = 32;
    localparam int DEPTH = 1 << AW;
    localparam int VW    = 2*NR + 3*W + 2 + AW + 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [W-1:0]  sram_wdata_o;
    logic [W-1:0]  sram_wmask_o;
    logic          sram_gnt_i = 1'b0;
    logic [W-1:0]  sram_rdata_i = '0;
    logic [15:0]   conflict_cnt_o;
    logic          cnt_clr_i = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    sim_sram_arb_if #(.NumReq(NR), .SramAw(AW), .Width(W)) bus ();

    sim_sram_arb #(.NumReq(NR), .SramAw(AW), .Width(W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bus            (bus),
        .sram_req_o     (sram_req_o),
        .sram_we_o      (sram_we_o),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_wmask_o   (sram_wmask_o),
        .sram_gnt_i     (sram_gnt_i),
        .sram_rdata_i   (sram_rdata_i),
        .conflict_cnt_o (conflict_cnt_o),
        .cnt_clr_i      (cnt_clr_i)
    );

    // ------------------------------------------------------------------------
    // SRAM model: masked writes, registered reads, noise on idle data lines.
    // ------------------------------------------------------------------------
    logic [W-1:0] sram_mem [DEPTH];

    always @(posedge clk_i) begin
        if (sram_req_o && sram_gnt_i && !sram_we_o) begin
            sram_rdata_i <= sram_mem[sram_addr_o];
        end else begin
            sram_rdata_i <= $urandom;
        end
        if (sram_req_o && sram_gnt_i && sram_we_o) begin
            sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_wmask_o) |
                                     (sram_wdata_o & sram_wmask_o);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus staging (t_*), snapshot of applied cycle (s_*), reference model
    // ------------------------------------------------------------------------
    bit           t_we    [NR];
    logic [AW-1:0] t_addr [NR];
    logic [W-1:0] t_wdata [NR];
    logic [W-1:0] t_wmask [NR];

    logic [NR-1:0] s_req;
    bit            s_sgnt;
    bit            s_clr;
    bit            s_we    [NR];
    logic [AW-1:0] s_addr  [NR];
    logic [W-1:0]  s_wdata [NR];
    logic [W-1:0]  s_wmask [NR];

    logic [W-1:0]  ref_mem [DEPTH];
    int            m_ptr;
    logic [NR-1:0] m_rv;
    logic [W-1:0]  m_rdata;
    logic [15:0]   m_cnt;
    int            m_win;
    bit            m_granted;
    bit            primed;
    logic [VW-1:0] exp_vec;

    function automatic logic [VW-1:0] obs_vec();
        return {bus.gnt_o, bus.rvalid_o, bus.rdata_o, sram_req_o, sram_we_o,
                sram_addr_o, sram_wdata_o, sram_wmask_o, conflict_cnt_o};
    endfunction

    task automatic set_port(input int k, input bit we, input logic [AW-1:0] addr,
                            input logic [W-1:0] wdata, input logic [W-1:0] wmask);
        t_we[k]    = we;
        t_addr[k]  = addr;
        t_wdata[k] = wdata;
        t_wmask[k] = wmask;
    endtask

    // Predict this cycle's outputs from the reference state and the inputs.
    task automatic model_expect();
        int            win;
        bit            found;
        logic [NR-1:0] g;
        logic [W-1:0]  e_rdata, e_wdata, e_wmask;
        logic [AW-1:0] e_addr;
        bit            e_we;
        found = 0;
        win   = 0;
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (m_ptr + i) % NR;
            if (!found && s_req[k]) begin
                found = 1;
                win   = k;
            end
        end
        m_win     = win;
        m_granted = found && s_sgnt;
        g = '0;
        if (m_granted) g[win] = 1'b1;
        e_rdata = (m_rv != 0) ? m_rdata : '0;
        e_we    = found ? s_we[win] : 1'b0;
        e_addr  = found ? s_addr[win] : '0;
        e_wdata = found ? s_wdata[win] : '0;
        e_wmask = found ? s_wmask[win] : '0;
        exp_vec = {g, m_rv, e_rdata, found, e_we, e_addr, e_wdata, e_wmask, m_cnt};
    endtask

    // Advance the reference by one rising edge.
    task automatic model_update();
        if (m_granted) begin
            if (s_we[m_win]) begin
                ref_mem[s_addr[m_win]] = (ref_mem[s_addr[m_win]] & ~s_wmask[m_win]) |
                                         (s_wdata[m_win] & s_wmask[m_win]);
                m_rv = '0;
            end else begin
                m_rv          = '0;
                m_rv[m_win]   = 1'b1;
                m_rdata       = ref_mem[s_addr[m_win]];
            end
            m_ptr = (m_win + 1) % NR;
        end else begin
            m_rv = '0;
        end
        if (s_clr) begin
            m_cnt = '0;
        end else if ($countones(s_req) >= 2 && m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    // Apply one cycle of stimulus on the falling edge and compute expectations.
    task automatic drive(input logic [NR-1:0] req, input bit sgnt, input bit clr);
        if (primed) begin
            @(posedge clk_i);
            model_update();
        end
        @(negedge clk_i);
        s_req  = req;
        s_sgnt = sgnt;
        s_clr  = clr;
        for (int k = 0; k < NR; k++) begin
            s_we[k]    = t_we[k];
            s_addr[k]  = t_addr[k];
            s_wdata[k] = t_wdata[k];
            s_wmask[k] = t_wmask[k];
            bus.we_i[k]                = t_we[k];
            bus.addr_i[k*AW +: AW]     = t_addr[k];
            bus.wdata_i[k*W +: W]      = t_wdata[k];
            bus.wmask_i[k*W +: W]      = t_wmask[k];
        end
        bus.req_i  = req;
        sram_gnt_i = sgnt;
        cnt_clr_i  = clr;
        #1;
        model_expect();
        primed = 1;
    endtask

    task automatic zero_inputs();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        bus.wmask_i = '0;
        sram_gnt_i  = 1'b0;
        cnt_clr_i   = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_rv   = '0;
        m_cnt  = '0;
        primed = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        zero_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_i       = 1'b1;
        bus.req_i   = '1;
        bus.we_i    = '0;
        sram_gnt_i  = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (bus.gnt_o !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt_o);
        end
        checks++;
        if (sram_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_sram_req: got %b expected 0", sram_req_o);
        end
        checks++;
        if (bus.rvalid_o !== 2'b00) begin
            errors++; $display("FAIL reset_rvalid: got %b expected 00", bus.rvalid_o);
        end
        checks++;
        if (conflict_cnt_o !== 16'h0000) begin
            errors++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt_o);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < NR; k++) set_port(k, 1'b1, AW'($urandom), $urandom, '1);
            drive(2'b11, 1'b1, 1'b0);
            checks++;
            if (bus.gnt_o !== exp_seq[c]) begin
                errors++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", c, bus.gnt_o, exp_seq[c]);
            end
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++; $display("FAIL rr_model cycle %0d: got %h expected %h", c, obs_vec(), exp_vec);
            end
        end
        drive(2'b00, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt_o !== 16'd4) begin
            errors++; $display("FAIL rr_cnt: got %0d expected 4", conflict_cnt_o);
        end
    endtask

    task automatic test_write_read();
        set_port(0, 1'b1, 3'd5, 32'hA5A5_0000, 32'hFFFF_FFFF);
        set_port(1, 1'b0, 3'd5, 32'h0, 32'h0);
        drive(2'b01, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b01) begin
            errors++; $display("FAIL wr_gnt: got %b expected 01", bus.gnt_o);
        end
        drive(2'b10, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b10 || bus.rvalid_o !== 2'b00) begin
            errors++; $display("FAIL rd_gnt: got gnt %b rvalid %b expected 10 00", bus.gnt_o, bus.rvalid_o);
        end
        drive(2'b00, 1'b0, 1'b0);
        checks++;
        if (bus.rvalid_o !== 2'b10 || bus.rdata_o !== 32'hA5A5_0000) begin
            errors++; $display("FAIL rd_return: got rvalid %b rdata %h expected 10 a5a50000", bus.rvalid_o, bus.rdata_o);
        end
        checks++;
        if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL rd_model: got %h expected %h", obs_vec(), exp_vec);
        end
    endtask

    task automatic test_mask();
        set_port(0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(2'b01, 1'b1, 1'b0);
        set_port(0, 1'b1, 3'd2, 32'h0000_0000, 32'h0000_FFFF);
        drive(2'b01, 1'b1, 1'b0);
        set_port(1, 1'b0, 3'd2, 32'h0, 32'h0);
        drive(2'b10, 1'b1, 1'b0);
        checks++;
        if (bus.rvalid_o !== 2'b00 || bus.rdata_o !== 32'h0) begin
            errors++; $display("FAIL mask_no_rvalid: got rvalid %b rdata %h expected 00 0", bus.rvalid_o, bus.rdata_o);
        end
        drive(2'b00, 1'b0, 1'b0);
        checks++;
        if (bus.rvalid_o !== 2'b10 || bus.rdata_o !== 32'hFFFF_0000) begin
            errors++; $display("FAIL mask_read: got rvalid %b rdata %h expected 10 ffff0000", bus.rvalid_o, bus.rdata_o);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        set_port(0, 1'b1, 3'd0, 32'h1, 32'h0);
        set_port(1, 1'b1, 3'd1, 32'h2, 32'h0);
        for (int c = 0; c < 3; c++) begin
            drive(2'b01, 1'b0, 1'b0);
            checks++;
            if (bus.gnt_o !== 2'b00 || sram_req_o !== 1'b1) begin
                errors++; $display("FAIL stall_gnt cycle %0d: got gnt %b req %b expected 00 1", c, bus.gnt_o, sram_req_o);
            end
        end
        drive(2'b01, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b01) begin
            errors++; $display("FAIL stall_release: got %b expected 01", bus.gnt_o);
        end
        for (int c = 0; c < 3; c++) drive(2'b11, 1'b0, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b10) begin
            errors++; $display("FAIL stall_ptr_hold: got %b expected 10", bus.gnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] eg;
        logic [NR-1:0] prev;
        do_reset();
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < NR; k++) set_port(k, 1'b0, AW'($urandom), 32'h0, 32'h0);
            drive(2'b11, 1'b1, 1'b0);
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.gnt_o !== eg || bus.rvalid_o !== prev) begin
                errors++; $display("FAIL b2b cycle %0d: got gnt %b rvalid %b expected %b %b", c, bus.gnt_o, bus.rvalid_o, eg, prev);
            end
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++; $display("FAIL b2b_model cycle %0d: got %h expected %h", c, obs_vec(), exp_vec);
            end
            prev = eg;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NR; k++) begin
                set_port(k, 1'($urandom), AW'($urandom), $urandom,
                         ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
            end
            drive(NR'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++; $display("FAIL random cycle %0d: got %h expected %h", c, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        set_port(0, 1'b0, 3'd3, 32'h0, 32'h0);
        drive(2'b01, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b01) begin
            errors++; $display("FAIL rstp_gnt: got %b expected 01", bus.gnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        zero_inputs();
        model_reset();
        @(negedge clk_i);
        #1;
        checks++;
        if (bus.rvalid_o !== 2'b00) begin
            errors++; $display("FAIL rstp_rvalid_in_reset: got %b expected 00", bus.rvalid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < NR; k++) set_port(k, 1'b0, AW'(k), 32'h0, 32'h0);
        drive(2'b11, 1'b1, 1'b0);
        checks++;
        if (bus.gnt_o !== 2'b01 || bus.rvalid_o !== 2'b00) begin
            errors++; $display("FAIL rstp_first_gnt: got gnt %b rvalid %b expected 01 00", bus.gnt_o, bus.rvalid_o);
        end
        checks++;
        if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL rstp_model: got %h expected %h", obs_vec(), exp_vec);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < NR; k++) set_port(k, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int c = 0; c < 65536; c++) drive(2'b11, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt_o !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach: got %h expected ffff", conflict_cnt_o);
        end
        for (int c = 0; c < 3; c++) drive(2'b11, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt_o !== 16'hFFFF || obs_vec() !== exp_vec) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt_o);
        end
        drive(2'b11, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt_o !== 16'h0000) begin
            errors++; $display("FAIL sat_clear: got %h expected 0000", conflict_cnt_o);
        end
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            logic [W-1:0] v;
            v = $urandom;
            sram_mem[a] = v;
            ref_mem[a]  = v;
        end
        for (int k = 0; k < NR; k++) set_port(k, 1'b0, '0, '0, '0);
        m_rdata = '0;
        model_reset();
        zero_inputs();

        test_reset();
        test_round_robin();
        test_write_read();
        test_mask();
        test_gnt_stall();
        test_back_to_back();
        test_random();
        test_reset_pending();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
